// File: rtl/serial_adc_frame_rx.sv
// Receive side of the ADC serial link: resynchronises spi_cs/sclk/mosi to clkin,
// deserialises LSB-first frames into parallel words and tags each word with a channel index.
module serial_adc_frame_rx #(
    parameter int unsigned WORD_BITS  = 12,
    parameter int unsigned NUM_CH     = 16,
    parameter int unsigned GAP_CYCLES = 256
) (
    input  logic                 clkin,
    input  logic                 rst_bar,
    input  logic                 spi_cs,
    input  logic                 sclk,
    input  logic                 mosi,
    output logic [WORD_BITS-1:0] data_out,
    output logic [3:0]           ch_idx,
    output logic                 word_valid,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int unsigned BIT_W = (WORD_BITS > 1) ? $clog2(WORD_BITS) : 1;
    localparam int unsigned GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam int unsigned CH_W  = 4;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    // [0]=s1, [1]=s2, [2]=s3 (history); mosi needs no history since only its level is used
    logic [2:0]           cs_sync_q, cs_sync_d;
    logic [2:0]           sclk_sync_q, sclk_sync_d;
    logic [1:0]           mosi_sync_q, mosi_sync_d;
    state_t               state_q, state_d;
    logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic [WORD_BITS-1:0] shreg_q, shreg_d;
    logic [CH_W-1:0]      chan_q, chan_d;
    logic [GAP_W-1:0]     gap_q, gap_d;
    logic                 ovr_q, ovr_d;
    logic [WORD_BITS-1:0] data_q, data_d;
    logic [CH_W-1:0]      ch_idx_q, ch_idx_d;
    logic                 word_valid_q, word_valid_d;
    logic                 frame_err_q, frame_err_d;
    logic                 busy_q, busy_d;

    logic cs_s2, cs_rise, cs_fall, sclk_rise, mosi_s2;

    // Edge detection on the synchronised copies only
    always_comb begin
        cs_s2     = cs_sync_q[1];
        cs_rise   = cs_sync_q[1] & ~cs_sync_q[2];
        cs_fall   = ~cs_sync_q[1] & cs_sync_q[2];
        sclk_rise = sclk_sync_q[1] & ~sclk_sync_q[2];
        mosi_s2   = mosi_sync_q[1];
    end

    // Next-state: synchronisers, frame FSM, channel counter and gap realignment
    always_comb begin
        cs_sync_d    = {cs_sync_q[1:0], spi_cs};
        sclk_sync_d  = {sclk_sync_q[1:0], sclk};
        mosi_sync_d  = {mosi_sync_q[0], mosi};
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shreg_d      = shreg_q;
        chan_d       = chan_q;
        gap_d        = gap_q;
        ovr_d        = ovr_q;
        data_d       = data_q;
        ch_idx_d     = ch_idx_q;
        word_valid_d = 1'b0;
        frame_err_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (cs_fall) begin
                    state_d   = SHIFT;
                    bit_cnt_d = '0;
                    shreg_d   = '0;
                end
            end
            SHIFT: begin
                if (sclk_rise) begin
                    shreg_d[bit_cnt_q] = mosi_s2;
                    bit_cnt_d          = bit_cnt_q + BIT_W'(1);
                    if (bit_cnt_q == BIT_W'(WORD_BITS - 1)) begin
                        // Final bit wins over a coincident cs rise: deliver, no error
                        data_d       = shreg_d;
                        ch_idx_d     = chan_q;
                        word_valid_d = 1'b1;
                        chan_d       = (chan_q == CH_W'(NUM_CH - 1)) ? '0 : chan_q + CH_W'(1);
                        ovr_d        = 1'b0;
                        state_d      = cs_rise ? IDLE : DONE;
                    end else if (cs_rise) begin
                        frame_err_d = 1'b1;
                        state_d     = IDLE;
                    end
                end else if (cs_rise) begin
                    frame_err_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            DONE: begin
                if (cs_rise) begin
                    frame_err_d = ovr_q | sclk_rise;
                    ovr_d       = 1'b0;
                    state_d     = IDLE;
                end else if (sclk_rise) begin
                    ovr_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (!cs_s2) begin
            gap_d = '0;
        end else if ((GAP_CYCLES != 0) && (state_q == IDLE) && (gap_q != GAP_W'(GAP_CYCLES))) begin
            gap_d = gap_q + GAP_W'(1);
            if (gap_d == GAP_W'(GAP_CYCLES)) begin
                chan_d = '0;
            end
        end

        busy_d = (state_d != IDLE);
    end

    // State register with synchronous active-low reset
    always_ff @(posedge clkin) begin
        if (!rst_bar) begin
            cs_sync_q    <= 3'b111;
            sclk_sync_q  <= 3'b111;
            mosi_sync_q  <= 2'b00;
            state_q      <= IDLE;
            bit_cnt_q    <= '0;
            shreg_q      <= '0;
            chan_q       <= '0;
            gap_q        <= '0;
            ovr_q        <= 1'b0;
            data_q       <= '0;
            ch_idx_q     <= '0;
            word_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            cs_sync_q    <= cs_sync_d;
            sclk_sync_q  <= sclk_sync_d;
            mosi_sync_q  <= mosi_sync_d;
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shreg_q      <= shreg_d;
            chan_q       <= chan_d;
            gap_q        <= gap_d;
            ovr_q        <= ovr_d;
            data_q       <= data_d;
            ch_idx_q     <= ch_idx_d;
            word_valid_q <= word_valid_d;
            frame_err_q  <= frame_err_d;
            busy_q       <= busy_d;
        end
    end

    assign data_out   = data_q;
    assign ch_idx     = ch_idx_q;
    assign word_valid = word_valid_q;
    assign frame_err  = frame_err_q;
    assign busy       = busy_q;

endmodule
